// File: rtl/addr_router.sv
// Address router: decodes a single master request onto one of N_SLV slave
// channels, waits for the slave's ready (bounded), and returns a one-cycle
// ready pulse with read data or an error flag.
module addr_router #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned N_SLV   = 2,
   parameter int unsigned SLV_AW  = 10,
   parameter logic [N_SLV*ADDR_W-1:0] BASE = 64'h0000_0000_0000_FF00,
   parameter logic [N_SLV*ADDR_W-1:0] MASK = 64'hFFFF_FC00_FFFF_FF00,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [DATA_W-1:0]         wdata,
   input  logic                      read,
   input  logic                      write,
   output logic [DATA_W-1:0]         rdata,
   output logic                      ready,
   output logic                      err,
   output logic [ADDR_W-1:0]         err_addr,
   output logic [N_SLV*SLV_AW-1:0]   s_addr,
   output logic [N_SLV*DATA_W-1:0]   s_wdata,
   input  logic [N_SLV*DATA_W-1:0]   s_rdata,
   output logic [N_SLV-1:0]          s_read,
   output logic [N_SLV-1:0]          s_write,
   input  logic [N_SLV-1:0]          s_ready
);

   localparam int unsigned CH_W  = (N_SLV > 1) ? $clog2(N_SLV) : 1;
   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP, RELEASE} state_t;

   state_t              state, state_nxt;
   logic                armed, armed_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [ADDR_W-1:0]   lat_addr, lat_addr_d;
   logic [DATA_W-1:0]   lat_wdata, lat_wdata_d;
   logic                lat_wr, lat_wr_d;
   logic [CH_W-1:0]     lat_ch, lat_ch_d;
   logic [DATA_W-1:0]   rdata_d;
   logic                ready_d, err_d;
   logic [ADDR_W-1:0]   err_addr_d;
   logic [N_SLV*SLV_AW-1:0] s_addr_d;
   logic [N_SLV*DATA_W-1:0] s_wdata_d;
   logic [N_SLV-1:0]    s_read_d, s_write_d;

   logic                dec_hit_c;
   logic [CH_W-1:0]     dec_ch_c;
   logic                accept_c, sel_ready_c, cnt_last_c, quiet_c;
   logic [DATA_W-1:0]   sel_rdata_c;
   logic                str_en_c, str_wr_c;
   logic [CH_W-1:0]     str_ch_c;
   logic [ADDR_W-1:0]   str_addr_c;
   logic [DATA_W-1:0]   str_wdata_c;

   // Address decode: scan high to low so the lowest matching index wins
   always_comb begin
      dec_hit_c = 1'b0;
      dec_ch_c  = '0;
      for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
         if ((addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
            dec_hit_c = 1'b1;
            dec_ch_c  = CH_W'(i);
         end
      end
   end

   assign accept_c    = (state == IDLE) && armed && (read || write);
   assign quiet_c     = !read && !write;
   assign sel_ready_c = s_ready[lat_ch];
   assign sel_rdata_c = s_rdata[lat_ch*DATA_W +: DATA_W];
   assign cnt_last_c  = (32'(cnt) + 32'd1) >= TIMEOUT;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept_c) state_nxt = dec_hit_c ? ACCESS : RESP;
         ACCESS:  if (sel_ready_c || cnt_last_c) state_nxt = RESP;
         RESP:    state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output/datapath next values; strobes are driven only while heading into ACCESS
   always_comb begin
      armed_d     = armed;
      cnt_d       = cnt;
      lat_addr_d  = lat_addr;
      lat_wdata_d = lat_wdata;
      lat_wr_d    = lat_wr;
      lat_ch_d    = lat_ch;
      rdata_d     = rdata;
      ready_d     = 1'b0;
      err_d       = 1'b0;
      err_addr_d  = err_addr;
      str_en_c    = 1'b0;
      str_wr_c    = lat_wr;
      str_ch_c    = lat_ch;
      str_addr_c  = lat_addr;
      str_wdata_c = lat_wdata;
      case (state)
         IDLE: begin
            if (quiet_c) armed_d = 1'b1;
            if (accept_c) begin
               lat_addr_d  = addr;
               lat_wdata_d = wdata;
               lat_wr_d    = write;
               lat_ch_d    = dec_ch_c;
               cnt_d       = '0;
               if (dec_hit_c) begin
                  str_en_c    = 1'b1;
                  str_wr_c    = write;
                  str_ch_c    = dec_ch_c;
                  str_addr_c  = addr;
                  str_wdata_c = wdata;
               end else begin
                  ready_d    = 1'b1;
                  err_d      = 1'b1;
                  rdata_d    = '0;
                  err_addr_d = addr;
               end
            end
         end
         ACCESS: begin
            if (sel_ready_c) begin
               ready_d = 1'b1;
               rdata_d = lat_wr ? '0 : sel_rdata_c;
            end else if (cnt_last_c) begin
               ready_d    = 1'b1;
               err_d      = 1'b1;
               rdata_d    = '0;
               err_addr_d = lat_addr;
            end else begin
               cnt_d    = cnt + CNT_W'(1);
               str_en_c = 1'b1;
            end
         end
         RESP:    armed_d = 1'b0;
         RELEASE: if (quiet_c) armed_d = 1'b1;
         default: ;
      endcase

      s_read_d  = '0;
      s_write_d = '0;
      s_addr_d  = '0;
      s_wdata_d = '0;
      for (int i = 0; i < int'(N_SLV); i++) begin
         if (str_en_c && (str_ch_c == CH_W'(i))) begin
            s_read_d[i]                  = !str_wr_c;
            s_write_d[i]                 = str_wr_c;
            s_addr_d[i*SLV_AW +: SLV_AW] = str_addr_c[SLV_AW-1:0];
            s_wdata_d[i*DATA_W +: DATA_W] = str_wdata_c;
         end
      end
   end

   // Registered outputs and request latches
   always_ff @(posedge clk) begin
      if (rst) begin
         armed     <= 1'b1;
         cnt       <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wr    <= 1'b0;
         lat_ch    <= '0;
         rdata     <= '0;
         ready     <= 1'b0;
         err       <= 1'b0;
         err_addr  <= '0;
         s_read    <= '0;
         s_write   <= '0;
         s_addr    <= '0;
         s_wdata   <= '0;
      end else begin
         armed     <= armed_d;
         cnt       <= cnt_d;
         lat_addr  <= lat_addr_d;
         lat_wdata <= lat_wdata_d;
         lat_wr    <= lat_wr_d;
         lat_ch    <= lat_ch_d;
         rdata     <= rdata_d;
         ready     <= ready_d;
         err       <= err_d;
         err_addr  <= err_addr_d;
         s_read    <= s_read_d;
         s_write   <= s_write_d;
         s_addr    <= s_addr_d;
         s_wdata   <= s_wdata_d;
      end
   end

endmodule

// File: tb/tb_addr_router.sv
// Directed bench for addr_router: expected responses are queued when a
// request is driven and compared whenever ready pulses.
module tb_addr_router;

   localparam int unsigned TO = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, wdata, rdata, err_addr;
   logic        read, write, ready, err;
   logic [19:0] s_addr;
   logic [63:0] s_wdata, s_rdata;
   logic [1:0]  s_read, s_write, s_ready;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [31:0] eaddr;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_eaddr = 32'h0;

   addr_router dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .read(read), .write(write),
      .rdata(rdata), .ready(ready), .err(err), .err_addr(err_addr),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
      .s_read(s_read), .s_write(s_write), .s_ready(s_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every ready pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_ready", 64'(ready), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("rdata", 64'(rdata), 64'(mon_e.rdata));
            chk("err", 64'(err), 64'(mon_e.err));
            chk("err_addr", 64'(err_addr), 64'(mon_e.eaddr));
         end
      end
   end

   // One master transaction; ch<0 means decode miss, waits<0 means slave never answers
   task automatic do_txn(input string tag, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int ch, input int waits, input logic [31:0] sd,
                         input bit hold);
      exp_t        e;
      int          lat, strobes, exp_lat, exp_str;
      logic [1:0]  e_rd, e_wr;
      logic [19:0] e_sa;
      logic [63:0] e_sw;
      addr = a; wdata = wd; read = rd; write = wr;
      if (ch < 0 || waits < 0) begin
         e.rdata = 32'h0; e.err = 1'b1; e.eaddr = a; exp_eaddr = a;
      end else begin
         e.rdata = wr ? 32'h0 : sd; e.err = 1'b0; e.eaddr = exp_eaddr;
      end
      sb.push_back(e);
      exp_lat = (ch < 0) ? 1 : (waits < 0) ? int'(TO) + 1 : waits + 2;
      exp_str = (ch < 0) ? 0 : (waits < 0) ? int'(TO) : waits + 1;
      tick;
      e_rd = '0; e_wr = '0; e_sa = '0; e_sw = '0;
      if (ch >= 0) begin
         e_rd[ch] = !wr;
         e_wr[ch] = wr;
         e_sa[ch*10 +: 10] = a[9:0];
         e_sw[ch*32 +: 32] = wd;
      end
      chk({tag, "_s_read"}, 64'(s_read), 64'(e_rd));
      chk({tag, "_s_write"}, 64'(s_write), 64'(e_wr));
      chk({tag, "_s_addr"}, 64'(s_addr), 64'(e_sa));
      chk({tag, "_s_wdata"}, s_wdata, e_sw);
      lat = 1; strobes = 0;
      while (ready !== 1'b1 && lat < 40) begin
         if (s_read != 2'b00 || s_write != 2'b00) strobes++;
         if (ch >= 0) begin
            s_ready[1-ch] = 1'b1;
            s_rdata[(1-ch)*32 +: 32] = 32'hBAD0_BAD0;
            if (waits >= 0 && lat == waits + 1) begin
               s_ready[ch] = 1'b1;
               s_rdata[ch*32 +: 32] = sd;
            end
            if (!hold) begin read = !rd; write = !wr; end
         end
         tick;
         s_ready = '0; s_rdata = '0;
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_strobe_cycles"}, 64'(strobes), 64'(exp_str));
      if (hold) begin
         read = rd; write = wr;
         for (int i = 0; i < 5; i++) begin
            tick;
            chk({tag, "_held_no_strobe"}, 64'({s_read, s_write}), 64'd0);
         end
         read = 1'b0; write = 1'b0;
         tick;
      end else begin
         read = 1'b0; write = 1'b0;
         tick;
         chk({tag, "_ready_one_cycle"}, 64'(ready), 64'd0);
         tick;
      end
   endtask

   initial begin
      rst = 1'b1; addr = '0; wdata = '0; read = 1'b0; write = 1'b0;
      s_rdata = '0; s_ready = '0;
      repeat (3) tick;
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_err_addr", 64'(err_addr), 64'd0);
      chk("rst_s_read", 64'(s_read), 64'd0);
      chk("rst_s_write", 64'(s_write), 64'd0);
      chk("rst_s_addr", 64'(s_addr), 64'd0);
      chk("rst_s_wdata", s_wdata, 64'd0);
      rst = 1'b0;
      tick;

      do_txn("rd_ch1",    1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1,  2, 32'hDEAD_BEEF, 1'b0);
      do_txn("wr_ch0",    1'b0, 1'b1, 32'h0000_FF04, 32'h0000_0012, 0,  0, 32'h1111_1111, 1'b0);
      do_txn("miss",      1'b1, 1'b0, 32'h0001_0000, 32'h0,        -1,  0, 32'h0,         1'b0);
      do_txn("timeout",   1'b1, 1'b0, 32'h0000_0100, 32'h0,         1, -1, 32'h0,         1'b0);
      do_txn("to_edge",   1'b1, 1'b0, 32'h0000_0104, 32'h0,         1, 14, 32'hCAFE_F00D, 1'b0);
      do_txn("rw_both",   1'b1, 1'b1, 32'h0000_FF08, 32'hA5A5_0001, 0,  1, 32'h2222_2222, 1'b0);
      do_txn("hold_1st",  1'b1, 1'b0, 32'h0000_03F0, 32'h0,         1,  0, 32'h0BAD_F00D, 1'b1);
      do_txn("hold_2nd",  1'b1, 1'b0, 32'h0000_03F0, 32'h0,         1,  1, 32'h1234_5678, 1'b0);

      // Reset in the middle of a channel-1 wait
      addr = 32'h0000_03FC; read = 1'b1;
      tick;
      tick;
      chk("mid_s_read", 64'(s_read), 64'd2);
      rst = 1'b1;
      tick;
      exp_eaddr = 32'h0;
      chk("mid_rst_s_read", 64'(s_read), 64'd0);
      chk("mid_rst_s_addr", 64'(s_addr), 64'd0);
      chk("mid_rst_err_addr", 64'(err_addr), 64'd0);
      chk("mid_rst_rdata", 64'(rdata), 64'd0);
      rst = 1'b0; read = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("mid_rst_no_ready", 64'(ready), 64'd0);
      end

      do_txn("post_rst",  1'b1, 1'b0, 32'h0000_FF10, 32'h0,         0,  0, 32'h0000_55AA, 1'b0);
      repeat (2) tick;
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/addr_router.md
ADDR_ROUTER -- requirements
Module: addr_router

Interface
REQ-001 SHALL have parameters ADDR_W, default 32, CPU address width.
REQ-002 SHALL have parameters DATA_W, default 32, data width on all ports.
REQ-003 SHALL have parameter N_SLV, default 2, number of slave channels (1..8).
REQ-004 SHALL have parameter SLV_AW, default 10, slave-side address width.
REQ-005 SHALL have parameters BASE and MASK, each N_SLV*ADDR_W flattened; defaults {0x0000FF00, 0x00000000} and {0xFFFFFF00, 0xFFFFFC00}, slice i = channel i.
REQ-006 SHALL have parameter TIMEOUT, default 15, maximum wait cycles for slave ready.
REQ-007 clk  in  1  single clock, all state on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 addr  in  ADDR_W  master address.
REQ-010 wdata  in  DATA_W  master write data.
REQ-011 read / write  in  1 each  master strobes, held until ready.
REQ-012 rdata  out  DATA_W  read data, valid while ready=1.
REQ-013 ready  out  1  one-cycle completion pulse.
REQ-014 err  out  1  valid with ready: decode miss or timeout.
REQ-015 err_addr  out  ADDR_W  address of most recent errored transaction, sticky.
REQ-016 s_addr  out  N_SLV*SLV_AW; s_wdata  out  N_SLV*DATA_W; s_rdata  in  N_SLV*DATA_W.
REQ-017 s_read / s_write / s_ready  out/out/in  N_SLV each, one bit per channel.

Function
REQ-018 SHALL implement FSM IDLE, ACCESS, RESP, RELEASE.
REQ-019 IDLE: when armed=1 and (read|write)=1, decode SHALL select the lowest index i with (addr & MASK_i) == BASE_i.
REQ-020 The master address, wdata, direction and channel SHALL be registered on acceptance; read and write both high SHALL be treated as write.
REQ-021 On a hit, the FSM SHALL go to ACCESS. On a miss, it SHALL go to RESP with err=1, rdata=0, err_addr=addr, and no slave strobe.
REQ-022 ACCESS: only the selected channel's s_read or s_write SHALL be 1, with s_addr_i = latched addr[SLV_AW-1:0] and s_wdata_i = latched wdata.
REQ-023 Unselected channel strobes SHALL be 0; their s_addr/s_wdata SHALL be 0.
REQ-024 ACCESS: on s_ready_i=1, the FSM SHALL capture s_rdata_i (reads; writes capture 0) and go to RESP; strobes SHALL drop the same edge.
REQ-025 Wait counter: SHALL clear on entering ACCESS and increment each ACCESS cycle without s_ready.
REQ-026 When the counter reaches TIMEOUT, the FSM SHALL go to RESP with err=1, rdata=0, err_addr latched, and the strobe dropped.
REQ-027 s_ready arriving in the same cycle the count hits TIMEOUT SHALL win: no error.
REQ-028 RESP: ready=1 for exactly one cycle, then RELEASE; armed SHALL clear.
REQ-029 RELEASE/IDLE: armed SHALL set after a cycle with read=write=0; a strobe held across the response SHALL NOT start a second transaction.
REQ-030 Latency: a hit with slave ready after k ACCESS cycles SHALL give ready k+2 cycles after acceptance; a miss SHALL give ready 1 cycle after acceptance.
REQ-031 s_ready on unselected channels, or outside ACCESS, SHALL be ignored.
REQ-032 Master strobes changing during ACCESS SHALL be ignored; the latched request governs.

Reset
REQ-033 rst=1 SHALL force IDLE, armed=1, and counter=0 at the next edge, including mid-transaction; any slave strobe SHALL drop that edge.
REQ-034 Reset values: ready=0, err=0, rdata=0, err_addr=0, and all s_read/s_write/s_addr/s_wdata = 0.

Verification
REQ-035 Read hit ch1: addr=0x000003FC, read=1; s_ready[1]=1 after 2 cycles, s_rdata=0xDEADBEEF -> s_read[1]=1 only, s_addr=0x3FC, ready pulse rdata=0xDEADBEEF err=0, 4 cycles after acceptance.
REQ-036 Write hit ch0: addr=0x0000FF04, wdata=0x12, s_ready[0] immediate -> s_write[0]=1, s_addr=0x304, s_wdata=0x12; ready err=0.
REQ-037 Miss: addr=0x00010000 read -> no strobe; ready next cycle; err=1, rdata=0, err_addr=0x00010000.
REQ-038 Timeout: ch1 read, s_ready never asserted -> strobe 15 ACCESS cycles, then ready err=1; boundary variant with s_ready on cycle 15 -> err=0.
REQ-039 Held strobe: read kept high 5 cycles after ready -> exactly one slave transaction; drop one cycle then re-raise -> a second transaction.
REQ-040 Reset mid-ACCESS: rst pulse during ch1 wait -> s_read[1]=0 next edge, ready never pulses, outputs at reset values.
